// File: rtl/logic_unit_pipe.sv
// Registered bitwise logic unit with a valid/ready handshake on both sides.
// One result register sits between the input and the output. It can take a
// new beat in the same cycle that it hands its current result downstream, so
// the unit sustains one beat per cycle while out_ready stays high. The zero,
// ones and parity flags are registered alongside the result. op_count tallies
// completed output transfers.
module logic_unit_pipe #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] e,
  output logic             zero,
  output logic             ones,
  output logic             parity,
  output logic [CNT_W-1:0] op_count
);

  localparam logic [2:0] OP_AND  = 3'b000;
  localparam logic [2:0] OP_OR   = 3'b001;
  localparam logic [2:0] OP_XOR  = 3'b010;
  localparam logic [2:0] OP_NOTA = 3'b011;
  localparam logic [2:0] OP_NAND = 3'b100;
  localparam logic [2:0] OP_NOR  = 3'b101;
  localparam logic [2:0] OP_XNOR = 3'b110;
  localparam logic [2:0] OP_PASB = 3'b111;

  // All eight codes are meaningful, so the default arm is never reached for
  // a known sel. It only keeps the function total.
  function automatic logic [WIDTH-1:0] bit_op(
    input logic [WIDTH-1:0] x,
    input logic [WIDTH-1:0] y,
    input logic [2:0]       op
  );
    logic [WIDTH-1:0] r;
    case (op)
      OP_AND:  r = x & y;
      OP_OR:   r = x | y;
      OP_XOR:  r = x ^ y;
      OP_NOTA: r = ~x;
      OP_NAND: r = ~(x & y);
      OP_NOR:  r = ~(x | y);
      OP_XNOR: r = ~(x ^ y);
      OP_PASB: r = y;
      default: r = y;
    endcase
    return r;
  endfunction

  function automatic logic is_zero(input logic [WIDTH-1:0] r);
    return ~|r;
  endfunction

  function automatic logic is_ones(input logic [WIDTH-1:0] r);
    return &r;
  endfunction

  function automatic logic odd_parity(input logic [WIDTH-1:0] r);
    return ^r;
  endfunction

  logic             vld_q,    vld_d;
  logic [WIDTH-1:0] e_q,      e_d;
  logic             zero_q,   zero_d;
  logic             ones_q,   ones_d;
  logic             parity_q, parity_d;
  logic [CNT_W-1:0] cnt_q,    cnt_d;

  logic             accept;
  logic             xfer;
  logic [WIDTH-1:0] result;

  // Handshake qualifiers. in_ready depends only on register state and
  // out_ready, never on in_valid.
  always_comb begin
    in_ready = !vld_q || out_ready;
    accept   = in_valid && in_ready;
    xfer     = vld_q && out_ready;
    result   = bit_op(a, b, sel);
  end

  // Next state of the result register: load on accept, drop valid on a bare
  // transfer, otherwise hold (this covers backpressure and idle cycles).
  always_comb begin
    vld_d    = vld_q;
    e_d      = e_q;
    zero_d   = zero_q;
    ones_d   = ones_q;
    parity_d = parity_q;
    cnt_d    = cnt_q;
    if (xfer) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    if (accept) begin
      vld_d    = 1'b1;
      e_d      = result;
      zero_d   = is_zero(result);
      ones_d   = is_ones(result);
      parity_d = odd_parity(result);
    end else if (xfer) begin
      vld_d = 1'b0;
    end
  end

  // State register. Reset overrides any handshake in the same cycle and
  // discards a held result.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q    <= 1'b0;
      e_q      <= '0;
      zero_q   <= 1'b1;
      ones_q   <= 1'b0;
      parity_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      vld_q    <= vld_d;
      e_q      <= e_d;
      zero_q   <= zero_d;
      ones_q   <= ones_d;
      parity_q <= parity_d;
      cnt_q    <= cnt_d;
    end
  end

  // Drive the registered outputs.
  always_comb begin
    out_valid = vld_q;
    e         = e_q;
    zero      = zero_q;
    ones      = ones_q;
    parity    = parity_q;
    op_count  = cnt_q;
  end

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Bench for logic_unit_pipe (WIDTH=32, CNT_W=4). A reference model built from
// per-bit truth tables and population counts tracks the expected outputs
// every cycle. Directed sequences cover the opcode sweep, the flags,
// backpressure, streaming, counter wrap and reset mid-operation. These are
// followed by randomized traffic.
module tb_logic_unit_pipe;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic [2:0]  sel;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] e;
  logic        zero;
  logic        ones;
  logic        parity;
  logic [3:0]  op_count;

  logic_unit_pipe #(.WIDTH(32), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .sel(sel), .out_valid(out_valid), .out_ready(out_ready),
    .e(e), .zero(zero), .ones(ones), .parity(parity), .op_count(op_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // Reference state
  logic        m_init = 1'b0;
  logic        m_vld;
  logic [31:0] m_e;
  logic        m_z, m_o, m_p;
  int          m_cnt;
  logic        last_rdy;

  logic [31:0] sweep_exp [8] = '{32'h00F0_1234, 32'hFFF0_FFFF, 32'hFF00_EDCB,
                                 32'h0F0F_EDCB, 32'hFF0F_EDCB, 32'h000F_0000,
                                 32'h00FF_1234, 32'h0FF0_FFFF};

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Truth table per opcode, indexed by {a_bit, b_bit}
  function automatic logic [31:0] ref_op(input logic [31:0] x, input logic [31:0] y,
                                         input logic [2:0] s);
    logic [3:0]  tt;
    logic [31:0] r;
    case (s)
      3'd0: tt = 4'b1000;
      3'd1: tt = 4'b1110;
      3'd2: tt = 4'b0110;
      3'd3: tt = 4'b0011;
      3'd4: tt = 4'b0111;
      3'd5: tt = 4'b0001;
      3'd6: tt = 4'b1001;
      default: tt = 4'b1010;
    endcase
    for (int i = 0; i < 32; i++) r[i] = tt[{x[i], y[i]}];
    return r;
  endfunction

  // One clock cycle: drive, check in_ready, clock, advance model, check outputs
  task automatic step(input logic iv, input logic [31:0] ia, input logic [31:0] ib,
                      input logic [2:0] is, input logic ordy, input logic irst);
    logic acc, xf;
    int   pc;
    in_valid = iv; a = ia; b = ib; sel = is; out_ready = ordy; rst = irst;
    #1;
    last_rdy = in_ready;
    if (m_init) chk("in_ready", {63'd0, in_ready}, {63'd0, !m_vld || ordy});
    acc = iv && (!m_vld || ordy);
    xf  = m_vld && ordy;
    @(posedge clk);
    #1;
    if (irst) begin
      m_init = 1'b1; m_vld = 1'b0; m_e = 32'd0;
      m_z = 1'b1; m_o = 1'b0; m_p = 1'b0; m_cnt = 0;
    end else if (m_init) begin
      if (xf) m_cnt = (m_cnt + 1) % 16;
      if (acc) begin
        m_e = ref_op(ia, ib, is);
        pc  = $countones(m_e);
        m_z = (pc == 0); m_o = (pc == 32); m_p = pc[0];
        m_vld = 1'b1;
      end else if (xf) begin
        m_vld = 1'b0;
      end
    end
    if (m_init) begin
      chk("out_valid", {63'd0, out_valid}, {63'd0, m_vld});
      chk("e",         {32'd0, e},         {32'd0, m_e});
      chk("zero",      {63'd0, zero},      {63'd0, m_z});
      chk("ones",      {63'd0, ones},      {63'd0, m_o});
      chk("parity",    {63'd0, parity},    {63'd0, m_p});
      chk("op_count",  {60'd0, op_count},  64'(m_cnt));
    end
  endtask

  logic [31:0] xa, xb, ya, yb, ra, rb;
  logic [31:0] exp_q [$];

  initial begin
    // Reset state
    step(1'b0, 32'd0, 32'd0, 3'd0, 1'b0, 1'b1);
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_e",         {32'd0, e},         64'd0);
    chk("rst_zero",      {63'd0, zero},      64'd1);
    chk("rst_op_count",  {60'd0, op_count},  64'd0);
    step(1'b0, 32'd0, 32'd0, 3'd0, 1'b0, 1'b0);
    chk("rst_in_ready", {63'd0, last_rdy}, 64'd1);

    // Opcode sweep
    for (int s = 0; s < 8; s++) begin
      step(1'b1, 32'hF0F0_1234, 32'h0FF0_FFFF, 3'(s), 1'b1, 1'b0);
      chk($sformatf("sweep_sel%0d", s), {32'd0, e}, {32'd0, sweep_exp[s]});
    end

    // Flags
    step(1'b1, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 3'd2, 1'b1, 1'b0);
    chk("xor_e", {32'd0, e}, 64'd0);
    chk("xor_zero", {63'd0, zero}, 64'd1);
    chk("xor_ones", {63'd0, ones}, 64'd0);
    chk("xor_parity", {63'd0, parity}, 64'd0);
    step(1'b1, 32'd0, 32'd0, 3'd5, 1'b1, 1'b0);
    chk("nor_e", {32'd0, e}, 64'hFFFF_FFFF);
    chk("nor_zero", {63'd0, zero}, 64'd0);
    chk("nor_ones", {63'd0, ones}, 64'd1);
    chk("nor_parity", {63'd0, parity}, 64'd0);
    step(1'b1, 32'd0, 32'd1, 3'd7, 1'b1, 1'b0);
    chk("pasb_parity", {63'd0, parity}, 64'd1);
    step(1'b0, 32'd0, 32'd0, 3'd0, 1'b1, 1'b0);

    // Backpressure
    xa = 32'h1234_5678; xb = 32'h0F0F_0F0F; ya = 32'hAAAA_5555; yb = 32'h3333_CCCC;
    step(1'b1, xa, xb, 3'd1, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, ya, yb, 3'd2, 1'b0, 1'b0);
      chk("bp_in_ready", {63'd0, last_rdy}, 64'd0);
      chk("bp_hold_e", {32'd0, e}, {32'd0, xa | xb});
    end
    step(1'b1, ya, yb, 3'd2, 1'b1, 1'b0);
    chk("bp_load_y", {32'd0, e}, {32'd0, ya ^ yb});
    chk("bp_valid", {63'd0, out_valid}, 64'd1);
    step(1'b0, 32'd0, 32'd0, 3'd0, 1'b1, 1'b0);

    // Streaming: 10 back-to-back beats
    step(1'b0, 32'd0, 32'd0, 3'd0, 1'b0, 1'b1);
    for (int i = 0; i < 10; i++) begin
      ra = $urandom; rb = $urandom;
      exp_q.push_back(ref_op(ra, rb, 3'(i % 8)));
      step(1'b1, ra, rb, 3'(i % 8), 1'b1, 1'b0);
      chk("stream_e", {32'd0, e}, {32'd0, exp_q.pop_front()});
      chk("stream_valid", {63'd0, out_valid}, 64'd1);
    end
    step(1'b0, 32'd0, 32'd0, 3'd0, 1'b1, 1'b0);
    chk("stream_count", {60'd0, op_count}, 64'd10);

    // Counter wrap: 17 transfers
    step(1'b0, 32'd0, 32'd0, 3'd0, 1'b0, 1'b1);
    for (int i = 0; i < 17; i++) step(1'b1, $urandom, $urandom, 3'd0, 1'b1, 1'b0);
    step(1'b0, 32'd0, 32'd0, 3'd0, 1'b1, 1'b0);
    chk("wrap_count", {60'd0, op_count}, 64'd1);

    // Reset while a result is held
    step(1'b1, 32'hCAFE_F00D, 32'h0, 3'd1, 1'b1, 1'b0);
    step(1'b0, 32'd0, 32'd0, 3'd0, 1'b0, 1'b0);
    step(1'b0, 32'd0, 32'd0, 3'd0, 1'b1, 1'b1);
    chk("mid_rst_valid", {63'd0, out_valid}, 64'd0);
    chk("mid_rst_e", {32'd0, e}, 64'd0);
    chk("mid_rst_zero", {63'd0, zero}, 64'd1);
    chk("mid_rst_count", {60'd0, op_count}, 64'd0);
    step(1'b0, 32'd0, 32'd0, 3'd0, 1'b1, 1'b0);
    chk("mid_rst_in_ready", {63'd0, last_rdy}, 64'd1);
    chk("mid_rst_dropped", {32'd0, e}, 64'd0);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 3) != 0), $urandom, $urandom, 3'($urandom_range(0, 7)),
           1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 49) == 0));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
